// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential four-digit BCD to binary converter (reverse double dabble, one bit per cycle)
module bcd_to_binary #(
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           thousands,
    input  logic [3:0]           hundreds,
    input  logic [3:0]           tens,
    input  logic [3:0]           ones,
    output logic [OUT_WIDTH-1:0] binary,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t                state, state_n;
    logic [15:0]           bcd, bcd_n, adj;
    logic [13:0]           res, res_n;
    logic [3:0]            count, count_n;
    logic [29:0]           sh;
    logic [OUT_WIDTH-1:0]  binary_n;
    logic                  busy_n, done_n, err_n, invalid;
    always_comb begin
        sh = {bcd, res} >> 1;
        adj = '0;
        // a field >= 8 after the shift carried a 10 down from the next digit: correct it
        for (int i = 0; i < 4; i++)
            adj[4*i+:4] = sh[14+4*i+:4] >= 4'd8 ? sh[14+4*i+:4] - 4'd3 : sh[14+4*i+:4];
        invalid = thousands > 4'd9 || hundreds > 4'd9 || tens > 4'd9 || ones > 4'd9;
        state_n = state;
        bcd_n = bcd;
        res_n = res;
        count_n = count;
        binary_n = binary;
        busy_n = busy;
        done_n = 1'b0;
        err_n = err;
        if (state == IDLE) begin
            if (start && invalid) begin
                binary_n = '0;
                err_n = 1'b1;
                done_n = 1'b1;
            end else if (start) begin
                bcd_n = {thousands, hundreds, tens, ones};
                res_n = '0;
                count_n = 4'd14;
                busy_n = 1'b1;
                state_n = SHIFT;
            end
        end else begin
            bcd_n = adj;
            res_n = sh[13:0];
            count_n = count - 4'd1;
            if (count == 4'd1) begin
                binary_n = OUT_WIDTH'(sh[13:0]);
                err_n = 1'b0;
                done_n = 1'b1;
                busy_n = 1'b0;
                state_n = IDLE;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            bcd <= '0;
            res <= '0;
            count <= '0;
            binary <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            bcd <= bcd_n;
            res <= res_n;
            count <= count_n;
            binary <= binary_n;
            busy <= busy_n;
            done <= done_n;
            err <= err_n;
        end
    end
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: randomized self-checking bench against an arithmetic reference model
module tb_bcd_to_binary;
    logic        clk = 0, reset = 1, start = 0;
    logic [3:0]  thousands = 0, hundreds = 0, tens = 0, ones = 0;
    logic [31:0] binary;
    logic        busy, done, err;
    int          checks = 0, failures = 0;

    bcd_to_binary #(.OUT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .thousands(thousands), .hundreds(hundreds),
        .tens(tens), .ones(ones), .binary(binary), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_digits(input logic [3:0] a, b, c, d);
        thousands = a; hundreds = b; tens = c; ones = d;
    endtask

    // one request; scramble pulses start and changes digits while the conversion runs
    task automatic conv(input logic [3:0] a, b, c, d, input bit scramble);
        bit bad;
        int expv, k;
        bad = a > 9 || b > 9 || c > 9 || d > 9;
        expv = bad ? 0 : a * 1000 + b * 100 + c * 10 + d;
        @(negedge clk);
        set_digits(a, b, c, d);
        start = 1;
        @(posedge clk);
        k = 0;
        @(negedge clk);
        start = 0;
        check("busy_start", {31'b0, busy}, {31'b0, !bad});
        while (!done && k < 30) begin
            if (scramble) begin
                set_digits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
                start = 1'($urandom);
            end
            @(posedge clk);
            k++;
            @(negedge clk);
            if (!done && busy !== 1'b1) check("busy_hold", {31'b0, busy}, 1);
        end
        start = 0;
        check("latency", k, bad ? 0 : 14);
        check("binary", binary, expv);
        check("err", {31'b0, err}, {31'b0, bad});
        check("busy_end", {31'b0, busy}, 0);
        @(posedge clk);
        @(negedge clk);
        check("done_pulse", {31'b0, done}, 0);
        check("no_restart", {31'b0, busy}, 0);
    endtask

    initial begin
        int dn;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_binary", binary, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_err", {31'b0, err}, 0);
        reset = 0;

        conv(1, 2, 3, 4, 0);
        conv(9, 9, 9, 9, 0);
        conv(0, 0, 0, 0, 0);
        conv(0, 0, 10, 5, 0);
        conv(5, 0, 0, 7, 1);

        // abort by reset partway through
        @(negedge clk);
        set_digits(8, 8, 8, 8);
        start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1;
        #1;
        check("abort_binary", binary, 0);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_done", {31'b0, done}, 0);
        @(negedge clk);
        reset = 0;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);
        conv(0, 0, 4, 2, 0);

        // back-to-back start in the done cycle
        @(negedge clk);
        set_digits(1, 2, 3, 4);
        start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        repeat (14) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("b2b_done1", {31'b0, done}, 1);
        check("b2b_bin1", binary, 1234);
        set_digits(0, 0, 0, 1);
        start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        check("b2b_busy", {31'b0, busy}, 1);
        repeat (13) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("b2b_hold", binary, 1234);
        check("b2b_early", {31'b0, done}, 0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_done2", {31'b0, done}, 1);
        check("b2b_bin2", binary, 1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0)
                conv(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            else
                conv(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                     4'($urandom_range(0, 9)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
